ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port RAM (we/addr/din in, registered dout, 1-cycle read latency)
//  between two requesters using round-robin arbitration.
//  After every reset, an init sequencer writes INIT_VAL to every address.
//  Only then does it accept requests. Sits between client logic and the RAM instance.
// PARAMETERS
//  AW        6      RAM address width; the init sweep covers 2**AW words
//  DW        8      RAM data width
//  INIT_VAL  8'h00  Value written to every word during the init sweep (DW bits)
// PORTS
//  clk        in   1   Single clock; all state updates on posedge clk
//  rst        in   1   Reset: synchronous, active-high
//  req0/req1  in   1   Access request, one per requester
//  we0/we1    in   1   1 = write, 0 = read; qualified by reqN
//  addr0/1    in   AW  Request address
//  din0/1     in   DW  Write data
//  gnt0/1     out  1   Access accepted this cycle (combinational)
//  rvalid0/1  out  1   rdata holds this requester's read result (registered)
//  rdata      out  DW  Read data, shared; passes through ram_dout
//  busy       out  1   Init sweep in progress; no grants while high
//  ram_we     out  1   Drives RAM we
//  ram_addr   out  AW  Drives RAM addr
//  ram_din    out  DW  Drives RAM din
//  ram_dout   in   DW  From RAM dout
// BEHAVIOUR
//  - FSM states: INIT, RUN. rst=1 forces INIT, init_cnt=0, busy=1, gnt*=0, rvalid*=0,
//    ram_we=0, rr_ptr=0 (requester 0 favoured). Reset mid-sweep or mid-traffic restarts
//    the sweep from address 0. Reads in flight are dropped (no rvalid).
//  - INIT: ram_we=1, ram_addr=init_cnt, ram_din=INIT_VAL, init_cnt+1 per cycle.
//    After writing address 2**AW-1, go to RUN. Sweep = 2**AW cycles after rst falls.
//    busy falls in the first RUN cycle.
//  - RUN arbitration (combinational, same cycle):
//    - Only one reqN high: grant it.
//    - Both high: grant rr_ptr.
//    - Neither high: ram_we=0, ram_addr/ram_din hold the last granted values.
//  - rr_ptr updates only on a grant: it points to the requester not granted.
//  - On a grant, ram_we/ram_addr/ram_din = the granted requester's weN/addrN/dinN.
//  - Handshake: a requester holds reqN, weN, addrN and dinN stable until it samples gntN=1
//    at a clock edge. It may keep reqN high for a new access on the next cycle.
//    One access per grant; a full grant every cycle gives 100% throughput.
//  - Read latency: for a read granted in cycle N, rvalidN=1 for exactly cycle N+1.
//    rdata=ram_dout then. Only one rvalid can be high per cycle.
//  - A write does not change ram_dout (the RAM holds its registered output).
//    rvalid stays 0 after a write grant.
//  - A read granted in the cycle after a write to the same address returns the new data.
//    Reading in the same cycle as a write is impossible (single port).
//  - gnt* and rvalid* are 0 while busy=1. Requests in INIT wait; they are not dropped.
//  - The RAM's own rst input is not driven by this block; the sweep does initialisation.
// TESTING
//  1. Deassert rst, no reqs -> busy=1 for 64 cycles, ram_we=1, ram_addr 0..63, ram_din=8'h00;
//     busy=0 on cycle 65.
//  2. After init: req0 write addr 5 = 8'hA5, then req0 read addr 5 -> gnt0 both cycles;
//     rvalid0=1 one cycle after the read grant, rdata=8'hA5.
//  3. req0 and req1 both held high, reading addr 1 and addr 2, for 6 cycles ->
//     grants alternate 0,1,0,1,0,1; rvalid alternates one cycle later with the correct data.
//  4. Unwritten addr 63 read after init -> rdata=INIT_VAL (8'h00); with INIT_VAL=8'h3C -> 8'h3C.
//  5. Assert rst at sweep address 20, release -> sweep restarts at addr 0; busy high 64 more cycles.
//  6. rst during read grant -> no rvalid next cycle; held req0 during busy is granted in the
//     first RUN cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-port front end for a single-port RAM with init sweep
module ram_port_arbiter #(
    parameter int            AW       = 6,
    parameter int            DW       = 8,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] init_cnt;
    logic          rr_ptr;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_din;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic          run_en;
    logic          g0;
    logic          g1;
    logic          sweep_done;

    assign sweep_done = (init_cnt == {AW{1'b1}});
    // Reset gates grants combinationally so an access presented during rst never reaches the RAM.
    assign run_en     = (state == S_RUN) && !rst;

    always_comb begin
        g0 = run_en && req0 && (!req1 || !rr_ptr);
        g1 = run_en && req1 && !g0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (sweep_done) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + AW'(1);
        end
    end

    // rr_ptr names the requester that wins the next tie: the one not served last.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (g0) begin
            rr_ptr <= 1'b1;
        end else if (g1) begin
            rr_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
            last_din  <= '0;
        end else if (g0) begin
            last_addr <= addr0;
            last_din  <= din0;
        end else if (g1) begin
            last_addr <= addr1;
            last_din  <= din1;
        end
    end

    // The RAM output register updates one cycle after a read grant; flag it to the reader.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= g0 && !we0;
            rvalid1_q <= g1 && !we1;
        end
    end

    always_comb begin
        gnt0     = g0;
        gnt1     = g1;
        rvalid0  = rvalid0_q && !rst;
        rvalid1  = rvalid1_q && !rst;
        rdata    = ram_dout;
        busy     = rst || (state == S_INIT);
        ram_we   = 1'b0;
        ram_addr = last_addr;
        ram_din  = last_din;
        if (state == S_INIT) begin
            ram_we   = !rst;
            ram_addr = init_cnt;
            ram_din  = INIT_VAL;
        end else if (g0) begin
            ram_we   = we0;
            ram_addr = addr0;
            ram_din  = din0;
        end else if (g1) begin
            ram_we   = we1;
            ram_addr = addr1;
            ram_din  = din1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [5:0] addr0, addr1;
    logic [7:0] din0, din1;

    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [7:0] rdata, ram_din, ram_dout;
    logic [5:0] ram_addr;
    logic       gnt0_c, gnt1_c, rvalid0_c, rvalid1_c, busy_c, ram_we_c;
    logic [7:0] rdata_c, ram_din_c, ram_dout_c;
    logic [5:0] ram_addr_c;

    logic [7:0] mem_a [64];
    logic [7:0] mem_c [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram_port_arbiter #(.AW(6), .DW(8), .INIT_VAL(8'h3C)) dut_c (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .gnt0(gnt0_c), .gnt1(gnt1_c), .rvalid0(rvalid0_c), .rvalid1(rvalid1_c),
        .rdata(rdata_c), .busy(busy_c), .ram_we(ram_we_c), .ram_addr(ram_addr_c),
        .ram_din(ram_din_c), .ram_dout(ram_dout_c)
    );

    // Single-port RAMs with registered output that holds during writes
    always @(posedge clk) begin
        if (ram_we) mem_a[ram_addr] <= ram_din;
        else        ram_dout <= mem_a[ram_addr];
    end

    always @(posedge clk) begin
        if (ram_we_c) mem_c[ram_addr_c] <= ram_din_c;
        else          ram_dout_c <= mem_c[ram_addr_c];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
    endtask

    typedef struct {
        logic       r0, w0;
        logic [5:0] a0;
        logic [7:0] d0;
        logic       r1, w1;
        logic [5:0] a1;
        logic [7:0] d1;
        logic       g0, g1, v0, v1;
        logic [7:0] rd;
        logic       we;
        logic       ac;
        logic [5:0] ae;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [5:0] a0,
                                input logic [7:0] d0, input logic r1, input logic w1,
                                input logic [5:0] a1, input logic [7:0] d1,
                                input logic g0, input logic g1, input logic v0,
                                input logic v1, input logic [7:0] rd, input logic we,
                                input logic ac, input logic [5:0] ae);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.rd = rd; v.we = we; v.ac = ac; v.ae = ae;
        return v;
    endfunction

    vec_t tbl [12];

    logic [7:0] mm [64];
    int         rr;
    logic       pv0, pv1, any_g, free0, free1, eg0, eg1, w;
    logic [7:0] pd, ld, d;
    logic [5:0] la, a;

    initial begin
        tbl[0]  = mk(1, 1, 6'd5, 8'hA5, 0, 0, 6'd0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 6'd0);
        tbl[1]  = mk(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 6'd0);
        tbl[2]  = mk(1, 1, 6'd1, 8'h11, 0, 0, 6'd0, 8'h00, 1, 0, 1, 0, 8'hA5, 1, 0, 6'd0);
        tbl[3]  = mk(0, 0, 6'd0, 8'h00, 1, 1, 6'd2, 8'h22, 0, 1, 0, 0, 8'h00, 1, 0, 6'd0);
        tbl[4]  = mk(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 6'd0);
        tbl[5]  = mk(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, 0, 1, 1, 0, 8'h11, 0, 0, 6'd0);
        tbl[6]  = mk(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, 1, 0, 0, 1, 8'h22, 0, 0, 6'd0);
        tbl[7]  = mk(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, 0, 1, 1, 0, 8'h11, 0, 0, 6'd0);
        tbl[8]  = mk(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, 1, 0, 0, 1, 8'h22, 0, 0, 6'd0);
        tbl[9]  = mk(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, 0, 1, 1, 0, 8'h11, 0, 0, 6'd0);
        tbl[10] = mk(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0, 0, 0, 1, 8'h22, 0, 1, 6'd2);
        tbl[11] = mk(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 6'd2);

        // Reset state and full init sweep
        rst = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        settle();
        chk("rst_busy", busy, 1);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_rvalid", {rvalid0, rvalid1}, 0);
        chk("rst_ram_we", ram_we, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            settle();
            chk("sweep_busy", busy, 1);
            chk("sweep_we", ram_we, 1);
            chk("sweep_addr", ram_addr, i);
            chk("sweep_din", ram_din, 8'h00);
            chk("sweep_gnt", {gnt0, gnt1}, 0);
            if (i == 0) chk("sweep_din_c", ram_din_c, 8'h3C);
            next_cycle();
        end
        settle();
        chk("busy_after_sweep", busy, 0);
        next_cycle();

        // Directed vectors: write/read-back and alternating round robin
        for (int i = 0; i < 12; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; din0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; din1 = tbl[i].d1;
            settle();
            chk($sformatf("v%0d_gnt0", i), gnt0, tbl[i].g0);
            chk($sformatf("v%0d_gnt1", i), gnt1, tbl[i].g1);
            chk($sformatf("v%0d_rvalid0", i), rvalid0, tbl[i].v0);
            chk($sformatf("v%0d_rvalid1", i), rvalid1, tbl[i].v1);
            chk($sformatf("v%0d_ram_we", i), ram_we, tbl[i].we);
            if (tbl[i].v0 || tbl[i].v1) chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
            if (tbl[i].ac) chk($sformatf("v%0d_hold_addr", i), ram_addr, tbl[i].ae);
            next_cycle();
        end

        // Unwritten word reads back the sweep value
        idle();
        req0 = 1'b1; addr0 = 6'd63;
        settle();
        chk("rd63_gnt0", gnt0, 1);
        next_cycle();
        idle();
        settle();
        chk("rd63_rvalid0", rvalid0, 1);
        chk("rd63_rdata", rdata, 8'h00);
        chk("rd63_rdata_c", rdata_c, 8'h3C);
        next_cycle();

        // Reset in the middle of the sweep restarts it from address 0
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) next_cycle();
        rst = 1'b1;
        settle();
        chk("midrst_addr", ram_addr, 20);
        chk("midrst_we", ram_we, 0);
        chk("midrst_busy", busy, 1);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            settle();
            chk("resweep_busy", busy, 1);
            chk("resweep_addr", ram_addr, i);
            next_cycle();
        end
        settle();
        chk("resweep_done", busy, 0);
        next_cycle();

        // Randomised traffic against a transaction-level model
        for (int i = 0; i < 64; i++) mm[i] = 8'h00;
        rr = 0; pv0 = 0; pv1 = 0; pd = '0; any_g = 0; la = '0; ld = '0;
        free0 = 1; free1 = 1;
        for (int n = 0; n < 400; n++) begin
            if (free0) begin
                req0 = ($urandom_range(0, 3) != 0); we0 = 1'($urandom_range(0, 1));
                addr0 = 6'($urandom_range(0, 7)); din0 = 8'($urandom);
            end
            if (free1) begin
                req1 = ($urandom_range(0, 3) != 0); we1 = 1'($urandom_range(0, 1));
                addr1 = 6'($urandom_range(0, 7)); din1 = 8'($urandom);
            end
            settle();
            eg0 = req0 && (!req1 || rr == 0);
            eg1 = req1 && !eg0;
            chk("rnd_gnt0", gnt0, eg0);
            chk("rnd_gnt1", gnt1, eg1);
            chk("rnd_rvalid0", rvalid0, pv0);
            chk("rnd_rvalid1", rvalid1, pv1);
            if (pv0 || pv1) chk("rnd_rdata", rdata, pd);
            w = eg0 ? we0 : we1;
            a = eg0 ? addr0 : addr1;
            d = eg0 ? din0 : din1;
            if (eg0 || eg1) begin
                chk("rnd_ram_we", ram_we, w);
                chk("rnd_ram_addr", ram_addr, a);
                chk("rnd_ram_din", ram_din, d);
            end else begin
                chk("rnd_idle_we", ram_we, 0);
                if (any_g) begin
                    chk("rnd_hold_addr", ram_addr, la);
                    chk("rnd_hold_din", ram_din, ld);
                end
            end
            pv0 = 0; pv1 = 0;
            if (eg0 || eg1) begin
                any_g = 1; la = a; ld = d;
                rr = eg0 ? 1 : 0;
                if (w) mm[a] = d;
                else begin
                    pv0 = eg0; pv1 = eg1; pd = mm[a];
                end
            end
            free0 = eg0 || !req0;
            free1 = eg1 || !req1;
            next_cycle();
        end
        idle();
        next_cycle();

        // Reset coinciding with a read grant; request held through the sweep
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
        rst = 1'b1;
        settle();
        chk("rstrd_gnt0", gnt0, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            settle();
            if (i == 0) chk("rstrd_no_rvalid", rvalid0, 0);
            chk("held_gnt0_busy", gnt0, 0);
            chk("held_busy", busy, 1);
            next_cycle();
        end
        settle();
        chk("held_busy_low", busy, 0);
        chk("held_gnt0_run", gnt0, 1);
        next_cycle();
        idle();
        settle();
        chk("held_rvalid0", rvalid0, 1);
        chk("held_rdata", rdata, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
